// File: rtl/serial.sv
// rtl/serial.sv - nibble-serial 64x64 Karatsuba multiplier with byte-serial product output
module serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       T_Ready,
    input  logic [3:0] Data_in1,
    input  logic [3:0] Data_in2,
    output logic [7:0] Data_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        COMBINE,
        SEND
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   a_q, a_d, b_q, b_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [63:0]   plo_q, plo_d, phi_q, phi_d;
    logic [65:0]   pmid_q, pmid_d;
    logic [127:0]  prod_q, prod_d;
    logic [7:0]    dout_q, dout_d;

    logic [32:0]   a_sum, b_sum;
    logic [65:0]   mid_term;
    logic [127:0]  combined;

    assign a_sum = {1'b0, a_q[63:32]} + {1'b0, a_q[31:0]};
    assign b_sum = {1'b0, b_q[63:32]} + {1'b0, b_q[31:0]};
    // Middle term is never negative, so the 66-bit difference is exact.
    assign mid_term = pmid_q - {2'b00, phi_q} - {2'b00, plo_q};
    assign combined = {phi_q, 64'd0} + {30'd0, mid_term, 32'd0} + {64'd0, plo_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        plo_d   = plo_q;
        phi_d   = phi_q;
        pmid_d  = pmid_q;
        prod_d  = prod_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                dout_d = 8'hFF;
                if (start) begin
                    a_d     = {60'd0, Data_in1};
                    b_d     = {60'd0, Data_in2};
                    cnt_d   = 4'd14;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d = {a_q[59:0], Data_in1};
                b_d = {b_q[59:0], Data_in2};
                if (cnt_q == 4'd0) begin
                    state_d = MUL_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MUL_LO: begin
                plo_d   = {32'd0, a_q[31:0]} * {32'd0, b_q[31:0]};
                state_d = MUL_HI;
            end
            MUL_HI: begin
                phi_d   = {32'd0, a_q[63:32]} * {32'd0, b_q[63:32]};
                state_d = MUL_MID;
            end
            MUL_MID: begin
                pmid_d  = {33'd0, a_sum} * {33'd0, b_sum};
                state_d = COMBINE;
            end
            COMBINE: begin
                prod_d  = combined;
                idx_d   = 5'd0;
                state_d = SEND;
            end
            SEND: begin
                // idx reaching 16 means all bytes are out; the next ready edge restores the marker.
                if (T_Ready) begin
                    if (idx_q == 5'd16) begin
                        dout_d  = 8'hFF;
                        idx_d   = 5'd0;
                        state_d = IDLE;
                    end else begin
                        dout_d = prod_q[{idx_q[3:0], 3'b000} +: 8];
                        idx_d  = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            cnt_q   <= 4'd0;
            idx_q   <= 5'd0;
            plo_q   <= 64'd0;
            phi_q   <= 64'd0;
            pmid_q  <= 66'd0;
            prod_q  <= 128'd0;
            dout_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            plo_q   <= plo_d;
            phi_q   <= phi_d;
            pmid_q  <= pmid_d;
            prod_q  <= prod_d;
            dout_q  <= dout_d;
        end
    end

    assign Data_out = dout_q;

endmodule

// File: tb/tb_serial.sv
// tb/tb_serial.sv - bench for serial: vector table, stall/reset/start corner cases, random products
module tb_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic       T_Ready;
    logic [3:0] Data_in1;
    logic [3:0] Data_in2;
    logic [7:0] Data_out;

    int checks;
    int errors;

    serial dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .T_Ready  (T_Ready),
        .Data_in1 (Data_in1),
        .Data_in2 (Data_in2),
        .Data_out (Data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        int           stall_k;
        bit           poke;
        string        name;
    } vec_t;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa;
        logic [127:0] wb;
        wa = {64'd0, a};
        wb = {64'd0, b};
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp,
                          input int stall_k, input bit poke, input string name);
        logic [127:0] got;
        got = '0;
        T_Ready = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        Data_in1 = a[63:60];
        Data_in2 = b[63:60];
        for (int i = 14; i >= 0; i--) begin
            @(negedge clk);
            start    = 1'b0;
            Data_in1 = a[4*i +: 4];
            Data_in2 = b[4*i +: 4];
        end
        // now just before E0+15; advance to just after E0+19
        repeat (5) @(negedge clk);
        check({name, " marker_before_byte0"}, {120'd0, Data_out}, 128'hFF);
        for (int k = 0; k < 16; k++) begin
            if (k == stall_k && k > 0) begin
                T_Ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check($sformatf("%s stall_hold_%0d", name, s), {120'd0, Data_out},
                          {120'd0, exp[8*(k-1) +: 8]});
                end
                T_Ready = 1'b1;
            end
            if (poke && k == 4) begin
                start    = 1'b1;
                Data_in1 = 4'hA;
                Data_in2 = 4'h5;
            end
            @(negedge clk);
            start = 1'b0;
            got[8*k +: 8] = Data_out;
        end
        check({name, " product"}, got, exp);
        @(negedge clk);
        check({name, " marker_after"}, {120'd0, Data_out}, 128'hFF);
    endtask

    vec_t vecs[7];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        T_Ready  = 1'b0;
        Data_in1 = 4'h0;
        Data_in2 = 4'h0;

        vecs[0] = '{64'd1, 64'd8, 128'd8, 0, 1'b0, "a1_b8"};
        vecs[1] = '{64'd2, 64'd3, 128'd6, 0, 1'b0, "a2_b3"};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                    128'hFFFFFFFFFFFFFFFE0000000000000001, 0, 1'b0, "all_ones"};
        vecs[3] = '{64'hFAFAFAFAFAFAFAFA, 64'hFAFAFAFAFAFAFAFA,
                    ref_mul(64'hFAFAFAFAFAFAFAFA, 64'hFAFAFAFAFAFAFAFA), 0, 1'b0, "fafa"};
        vecs[4] = '{64'h1000000000000000, 64'h1000000000000000,
                    128'h01000000000000000000000000000000, 0, 1'b0, "top_nibble"};
        vecs[5] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                    ref_mul(64'h0123456789ABCDEF, 64'hFEDCBA9876543210), 6, 1'b0, "stall"};
        vecs[6] = '{64'h00000000DEADBEEF, 64'h00000001FFFFFFFF,
                    ref_mul(64'h00000000DEADBEEF, 64'h00000001FFFFFFFF), 0, 1'b1, "start_in_send"};

        repeat (2) @(negedge clk);
        check("reset_marker", {120'd0, Data_out}, 128'hFF);
        rst = 1'b1;
        @(negedge clk);
        check("idle_marker", {120'd0, Data_out}, 128'hFF);

        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].stall_k, vecs[v].poke, vecs[v].name);
        end

        // reset in the middle of LOAD discards the partial operands
        @(negedge clk);
        start    = 1'b1;
        Data_in1 = 4'hF;
        Data_in2 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start    = 1'b0;
            Data_in1 = 4'h9;
            Data_in2 = 4'h6;
        end
        rst = 1'b0;
        #1;
        check("async_reset_marker", {120'd0, Data_out}, 128'hFF);
        @(negedge clk);
        rst = 1'b1;
        run_op(64'd5, 64'd7, 128'd35, 0, 1'b0, "after_reset");

        for (int r = 0; r < 20; r++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(ra, rb, ref_mul(ra, rb), (r % 4 == 1) ? int'($urandom_range(1, 15)) : 0, 1'b0,
                   $sformatf("rand_%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
